mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Request/response front end that sits directly upstream of the 8-bit `memory` block.
- Accepts one load or store from the core's execute/load-store stage over a valid/ready handshake.
- Sequences `mem_read`/`mem_write`, `address` and `input_data` into `memory` for a fixed number of wait cycles, then captures `output_data`.
- Returns the load data, or a store acknowledge, over a second valid/ready handshake; one transaction outstanding at a time.

Parameters:
- DATA_W, 8, data width; must equal the memory data width.
- ADDR_W, 8, address width; must equal the memory address width.
- MEM_LAT, 1, extra cycles the memory strobes are held after the first access cycle. Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  core accepts the response.
- rsp_we  output  1  echo of req_we for the transaction.
- rsp_rdata  output  DATA_W  load data; 0 for stores.
- mem_read  output  1  to `memory.mem_read`.
- mem_write  output  1  to `memory.mem_write`.
- mem_address  output  ADDR_W  to `memory.address`.
- mem_wdata  output  DATA_W  to `memory.input_data`.
- mem_rdata  input  DATA_W  from `memory.output_data`.

Behaviour:
- One clock (`clk`); reset is asynchronous, active-low (`rst_n`).
- All outputs are registered.
- Reset values:
  - req_ready=1 (IDLE).
  - rsp_valid, rsp_we, rsp_rdata = 0.
  - mem_read, mem_write, mem_address, mem_wdata = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at an edge: latch addr, wdata and we; clear the wait counter; go to ACCESS.
  - Also at that edge: set mem_address and mem_wdata; set mem_read=!req_we or mem_write=req_we.
- ACCESS:
  - req_ready=0; the strobe and address are held stable.
  - Lasts exactly MEM_LAT+1 cycles; the counter counts 0..MEM_LAT.
  - At the edge ending the last ACCESS cycle:
    - Load: rsp_rdata <= mem_rdata. Store: rsp_rdata <= 0.
    - rsp_we <= latched we; rsp_valid <= 1.
    - mem_read and mem_write <= 0; mem_address and mem_wdata keep their values.
    - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_we are held stable until rsp_ready.
  - On rsp_valid && rsp_ready at an edge: rsp_valid <= 0, req_ready <= 1, go to IDLE.
  - rsp_rdata keeps its value after the handshake.
- Latency with MEM_LAT=1:
  - Request accepted at edge 0.
  - Strobe high in cycles 1–2; data captured at edge 2.
  - rsp_valid high from cycle 3.
  - With rsp_ready held high, req_ready returns in cycle 4; back-to-back throughput is 1 transaction per MEM_LAT+3 cycles.
- Invariants:
  - mem_read and mem_write are never both 1.
  - Neither strobe is high outside ACCESS.
- Request acceptance and inputs:
  - req_valid while req_ready=0 is ignored; the request is not lost, the core holds it until accepted.
  - Request inputs are sampled only at the accept edge; later changes have no effect on the transaction.
- Address: full ADDR_W range; no bounds check and no wrap logic is needed.
- Reset asserted mid-transaction:
  - All outputs go to reset values immediately; FSM goes to IDLE.
  - The transaction is dropped with no response.
  - A store interrupted in ACCESS may or may not have written; the core must not rely on it.
- MEM_LAT=0: single ACCESS cycle; capture at the edge ending it.

Decomposition:
- Package `risc_me_mem_pkg`:
  - State enum (IDLE, ACCESS, RESP).
  - DATA_W/ADDR_W default constants.
  - Counter width constant (4 bits, covers MEM_LAT up to 15).
- One sub-module, `mem_wait_counter`: load-to-zero, increment and done-flag (count==MEM_LAT).
- The FSM and datapath registers stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-run -> all outputs 0, req_ready=1, within the same cycle (async).
- Store then load:
  - Store addr=0x02, wdata=0xAA -> mem_write high exactly 2 cycles with mem_address=0x02, mem_wdata=0xAA; response rsp_we=1, rsp_rdata=0x00.
  - Load addr=0x02 -> mem_read high exactly 2 cycles; rsp_rdata=0xAA, rsp_we=0.
- Backpressure: load addr=0x01 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, no strobes; releasing rsp_ready -> req_ready=1 the next cycle.
- Ignored request: req_valid with addr=0x10 during ACCESS -> ignored (no second strobe sequence until IDLE).
- Reset mid-ACCESS: rst_n pulse during a store to addr=0x03 -> strobes drop immediately, no rsp_valid afterwards, next transaction completes normally.
- Latency sweep: MEM_LAT=0 and MEM_LAT=3 builds, load 0xFF address -> strobe widths 1 and 4 cycles; rsp_valid at accept+2 and accept+5 edges.

Source files
------------

// File: rtl/risc_me_mem_pkg.sv
// Shared types and constants for the memory access unit.
//   state_t    : sequencer states (IDLE, ACCESS, RESP)
//   DATA_W_DEF : default data width, matches the 8-bit memory block
//   ADDR_W_DEF : default address width, matches the 8-bit memory block
//   CNT_W      : wait counter width, covers MEM_LAT up to 15
package risc_me_mem_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for the memory access phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : force the count to zero (takes priority over i_inc)
//   i_inc      : advance the count by one
//   o_done     : count has reached MEM_LAT
module mem_wait_counter
    import risc_me_mem_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == CNT_W'(MEM_LAT));

endmodule

// File: rtl/mem_access_unit.sv
// Request/response front end for the 8-bit memory block. Accepts one load
// or store at a time, drives the memory strobes for MEM_LAT+1 cycles,
// captures read data and returns it over a response handshake.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   req_valid/req_ready           : request handshake
//   req_we, req_addr, req_wdata   : request (1 = store), sampled at accept
//   rsp_valid/rsp_ready           : response handshake
//   rsp_we, rsp_rdata             : echoed we, load data (0 for stores)
//   mem_read, mem_write           : memory strobes, high only in ACCESS
//   mem_address, mem_wdata        : memory address / write data
//   mem_rdata                     : memory read data
// All outputs come straight from registers.
module mem_access_unit
    import risc_me_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    state_t            w_next;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_we;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_we;

    logic              w_accept;
    logic              w_last;
    logic              w_rsp_hs;
    logic              w_inc;
    logic              w_done;

    mem_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_accept),
        .i_inc   (w_inc),
        .o_done  (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        w_rsp_hs = 1'b0;
        w_inc    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_accept = req_valid && r_req_ready;
                if (w_accept) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Counter stops at MEM_LAT; done marks the final access cycle.
                w_last = w_done;
                w_inc  = !w_done;
                if (w_done) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_hs = r_rsp_valid && rsp_ready;
                if (w_rsp_hs) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_we      <= 1'b0;
            r_rsp_rdata   <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_we          <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req_ready   <= 1'b0;
                r_we          <= req_we;
                r_mem_address <= req_addr;
                r_mem_wdata   <= req_wdata;
                r_mem_read    <= !req_we;
                r_mem_write   <= req_we;
            end
            if (w_last) begin
                r_rsp_rdata <= r_we ? '0 : mem_rdata;
                r_rsp_we    <= r_we;
                r_rsp_valid <= 1'b1;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end
            if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
                r_req_ready <= 1'b1;
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_we      = r_rsp_we;
    assign rsp_rdata   = r_rsp_rdata;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Three instances (MEM_LAT = 0, 1, 3),
// each with its own behavioural memory (write on rising edge, combinational
// read, initial contents mem[a] = a ^ 8'h5A).
`define CHK(TAG, OBS, EXP) \
    n_assert++; \
    assert ((OBS) === (EXP)) else begin \
        n_fail++; \
        $error("FAIL %s: observed 0x%0h expected 0x%0h", TAG, OBS, EXP); \
    end

module tb_mem_access_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req_valid;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_ready;

    wire  [2:0] w_req_ready;
    wire  [2:0] w_rsp_valid;
    wire  [2:0] w_rsp_we;
    wire  [2:0] w_mem_read;
    wire  [2:0] w_mem_write;
    wire  [7:0] w_rsp_rdata   [3];
    wire  [7:0] w_mem_address [3];
    wire  [7:0] w_mem_wdata   [3];
    wire  [7:0] w_mem_rdata   [3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic [7:0] mem [256];
        bit         init_done = 1'b0;

        mem_access_unit #(
            .DATA_W  (8),
            .ADDR_W  (8),
            .MEM_LAT (LAT)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_valid   (req_valid[g]),
            .req_ready   (w_req_ready[g]),
            .req_we      (req_we),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .rsp_valid   (w_rsp_valid[g]),
            .rsp_ready   (rsp_ready),
            .rsp_we      (w_rsp_we[g]),
            .rsp_rdata   (w_rsp_rdata[g]),
            .mem_read    (w_mem_read[g]),
            .mem_write   (w_mem_write[g]),
            .mem_address (w_mem_address[g]),
            .mem_wdata   (w_mem_wdata[g]),
            .mem_rdata   (w_mem_rdata[g])
        );

        always @(posedge clk) begin
            if (!init_done) begin
                for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
                init_done <= 1'b1;
            end else if (w_mem_write[g]) begin
                mem[w_mem_address[g]] <= w_mem_wdata[g];
            end
        end

        assign w_mem_rdata[g] = mem[w_mem_address[g]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input int k, input string t);
        `CHK({t, "_req_ready"},   w_req_ready[k],   1'b1)
        `CHK({t, "_rsp_valid"},   w_rsp_valid[k],   1'b0)
        `CHK({t, "_rsp_we"},      w_rsp_we[k],      1'b0)
        `CHK({t, "_rsp_rdata"},   w_rsp_rdata[k],   8'h00)
        `CHK({t, "_mem_read"},    w_mem_read[k],    1'b0)
        `CHK({t, "_mem_write"},   w_mem_write[k],   1'b0)
        `CHK({t, "_mem_address"}, w_mem_address[k], 8'h00)
        `CHK({t, "_mem_wdata"},   w_mem_wdata[k],   8'h00)
    endtask

    // Issues one request to instance k (which must be idle), then watches it
    // cycle by cycle until rsp_valid. lat is the cycle index (accept edge =
    // edge 0) in which rsp_valid is first seen; 0 means it never came.
    // bad counts cycles with both strobes high or with an unstable address
    // or write data while a strobe is high. With hold_req the request stays
    // valid but is switched to a load of 0x10 right after the accept edge.
    task automatic run_txn(input int k, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata, input bit hold_req,
                           output int rd_n, output int wr_n,
                           output int lat, output int bad);
        rd_n = 0;
        wr_n = 0;
        lat  = 0;
        bad  = 0;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid[k] = 1'b1;
        tick();
        if (hold_req) begin
            req_we    = 1'b0;
            req_addr  = 8'h10;
            req_wdata = 8'h00;
        end else begin
            req_valid[k] = 1'b0;
        end
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (w_rsp_valid[k]) begin
                lat = cyc;
                break;
            end
            if (w_mem_read[k])  rd_n++;
            if (w_mem_write[k]) wr_n++;
            if (w_mem_read[k] && w_mem_write[k]) bad++;
            if ((w_mem_read[k] || w_mem_write[k]) &&
                (w_mem_address[k] !== addr || w_mem_wdata[k] !== wdata)) bad++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rd, wr, lat, bad;

        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;
        repeat (2) tick();
        chk_rst(1, "por");
        #2 rst_n = 1'b1;
        tick();

        // Store 0xAA to 0x02
        run_txn(1, 1'b1, 8'h02, 8'hAA, 1'b0, rd, wr, lat, bad);
        `CHK("st_wr_cycles", wr, 2)
        `CHK("st_rd_cycles", rd, 0)
        `CHK("st_latency", lat, 3)
        `CHK("st_stable", bad, 0)
        `CHK("st_rsp_we", w_rsp_we[1], 1'b1)
        `CHK("st_rsp_rdata", w_rsp_rdata[1], 8'h00)
        `CHK("st_strobes_off", {w_mem_read[1], w_mem_write[1]}, 2'b00)
        `CHK("st_addr_kept", w_mem_address[1], 8'h02)
        `CHK("st_wdata_kept", w_mem_wdata[1], 8'hAA)
        `CHK("st_req_ready_low", w_req_ready[1], 1'b0)
        tick();
        `CHK("st_req_ready_back", w_req_ready[1], 1'b1)
        `CHK("st_rsp_valid_clr", w_rsp_valid[1], 1'b0)

        // Load back from 0x02
        run_txn(1, 1'b0, 8'h02, 8'h00, 1'b0, rd, wr, lat, bad);
        `CHK("ld_rd_cycles", rd, 2)
        `CHK("ld_wr_cycles", wr, 0)
        `CHK("ld_latency", lat, 3)
        `CHK("ld_stable", bad, 0)
        `CHK("ld_rsp_we", w_rsp_we[1], 1'b0)
        `CHK("ld_rsp_rdata", w_rsp_rdata[1], 8'hAA)
        tick();
        `CHK("ld_req_ready_back", w_req_ready[1], 1'b1)

        // Backpressure: load 0x01 (initial contents 0x01^0x5A = 0x5B)
        rsp_ready = 1'b0;
        run_txn(1, 1'b0, 8'h01, 8'h00, 1'b0, rd, wr, lat, bad);
        `CHK("bp_rd_cycles", rd, 2)
        `CHK("bp_latency", lat, 3)
        for (int i = 0; i < 5; i++) begin
            tick();
            `CHK("bp_rsp_valid_hold", w_rsp_valid[1], 1'b1)
            `CHK("bp_rsp_rdata_hold", w_rsp_rdata[1], 8'h5B)
            `CHK("bp_req_ready_low", w_req_ready[1], 1'b0)
            `CHK("bp_no_strobe", {w_mem_read[1], w_mem_write[1]}, 2'b00)
        end
        rsp_ready = 1'b1;
        tick();
        `CHK("bp_release_ready", w_req_ready[1], 1'b1)
        `CHK("bp_release_valid", w_rsp_valid[1], 1'b0)
        `CHK("bp_rdata_kept", w_rsp_rdata[1], 8'h5B)

        // Request held through ACCESS/RESP (switched to load 0x10) is only
        // taken once the unit is back in IDLE.
        run_txn(1, 1'b0, 8'h02, 8'h00, 1'b1, rd, wr, lat, bad);
        `CHK("ign_rd_cycles", rd, 2)
        `CHK("ign_latency", lat, 3)
        `CHK("ign_stable", bad, 0)
        `CHK("ign_rsp_rdata", w_rsp_rdata[1], 8'hAA)
        tick();
        `CHK("ign_idle_ready", w_req_ready[1], 1'b1)
        `CHK("ign_idle_no_strobe", w_mem_read[1], 1'b0)
        tick();
        req_valid[1] = 1'b0;
        `CHK("ign_second_read", w_mem_read[1], 1'b1)
        `CHK("ign_second_addr", w_mem_address[1], 8'h10)
        for (int i = 0; i < 10 && !w_rsp_valid[1]; i++) tick();
        `CHK("ign_second_valid", w_rsp_valid[1], 1'b1)
        `CHK("ign_second_rdata", w_rsp_rdata[1], 8'h4A)
        tick();
        `CHK("ign_second_done", w_req_ready[1], 1'b1)

        // Reset pulse in the middle of a store to 0x03
        req_we       = 1'b1;
        req_addr     = 8'h03;
        req_wdata    = 8'h77;
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        `CHK("mid_write_active", w_mem_write[1], 1'b1)
        rst_n = 1'b0;
        #1;
        chk_rst(1, "mid");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            `CHK("mid_no_rsp", w_rsp_valid[1], 1'b0)
        end
        `CHK("mid_idle_ready", w_req_ready[1], 1'b1)
        run_txn(1, 1'b0, 8'h02, 8'h00, 1'b0, rd, wr, lat, bad);
        `CHK("mid_next_latency", lat, 3)
        `CHK("mid_next_rdata", w_rsp_rdata[1], 8'hAA)
        tick();

        // Latency sweep: load 0xFF (0xFF^0x5A = 0xA5)
        run_txn(0, 1'b0, 8'hFF, 8'h00, 1'b0, rd, wr, lat, bad);
        `CHK("lat0_rd_cycles", rd, 1)
        `CHK("lat0_latency", lat, 2)
        `CHK("lat0_stable", bad, 0)
        `CHK("lat0_rsp_rdata", w_rsp_rdata[0], 8'hA5)
        tick();
        `CHK("lat0_ready_back", w_req_ready[0], 1'b1)
        run_txn(2, 1'b0, 8'hFF, 8'h00, 1'b0, rd, wr, lat, bad);
        `CHK("lat3_rd_cycles", rd, 4)
        `CHK("lat3_latency", lat, 5)
        `CHK("lat3_stable", bad, 0)
        `CHK("lat3_rsp_rdata", w_rsp_rdata[2], 8'hA5)
        tick();
        `CHK("lat3_ready_back", w_req_ready[2], 1'b1)

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`undef CHK
